// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and defaults for the MIPS pipeline stages
package mips_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD_ALT = 2'b10, SZ_WORD = 2'b11} size_e;
  localparam int MEM_READ = 3, MEM_WRITE = 2, WB_REGWRITE = 1, WB_MEMTOREG = 0;
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? off[0] : off != 2'b00;
  endfunction
endpackage

// File: rtl/data_memory.sv
// data_memory: word array with byte-lane write enables and combinational reads
module data_memory import mips_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic [DATA_WIDTH/8-1:0]  be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around the data memory
module mem_stage import mips_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int MEM_DEPTH = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [DATA_WIDTH-1:0]        i_aluresult,
  input  logic [DATA_WIDTH-1:0]        i_regB,
  input  logic [4:0]                   i_rd_rt,
  input  logic [3:0]                   i_mem,
  input  logic                         i_unsigned,
  input  logic [1:0]                   i_wb,
  input  logic                         i_halt,
  input  logic                         i_flush,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic [DATA_WIDTH-1:0]        o_exmem_aluresult,
  output logic [4:0]                   o_exmem_rd,
  output logic                         o_exmem_regwrite,
  output logic [DATA_WIDTH-1:0]        o_wb_data,
  output logic [4:0]                   o_wb_rd,
  output logic                         o_wb_regwrite,
  output logic                         o_misaligned,
  output logic [DATA_WIDTH-1:0]        o_debug_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] ex_alu, ex_b, rdata, ld, wdata;
  logic [4:0] ex_rd;
  logic [3:0] ex_mem;
  logic [1:0] ex_wb;
  logic ex_uns, bad;
  logic [NB-1:0] lanes, be;
  logic [7:0] b8;
  logic [15:0] h16;
  size_e sz;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      ex_alu <= '0;
      ex_b <= '0;
      ex_rd <= '0;
      ex_mem <= '0;
      ex_uns <= 1'b0;
      ex_wb <= '0;
      o_wb_data <= '0;
      o_wb_rd <= '0;
      o_wb_regwrite <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      ex_alu <= i_aluresult;
      ex_b <= i_regB;
      ex_rd <= i_rd_rt;
      ex_uns <= i_unsigned;
      ex_mem <= i_flush ? '0 : i_mem;
      ex_wb <= i_flush ? '0 : i_wb;
      o_wb_data <= ex_wb[WB_MEMTOREG] ? ld : ex_alu;
      o_wb_rd <= ex_rd;
      o_wb_regwrite <= ex_wb[WB_REGWRITE];
      o_misaligned <= bad;
    end
  // Stores fan the source bytes across all lanes; the enables pick which lanes land.
  always_comb begin
    sz = size_e'(ex_mem[1:0]);
    bad = (ex_mem[MEM_READ] | ex_mem[MEM_WRITE]) & misaligned(sz, ex_alu[1:0]);
    lanes = sz == SZ_BYTE ? NB'(1) << ex_alu[1:0] : sz == SZ_HALF ? NB'(3) << {ex_alu[1], 1'b0} : '1;
    be = ex_mem[MEM_WRITE] && !bad && !i_halt && !i_reset ? lanes : '0;
    wdata = sz == SZ_BYTE ? {NB{ex_b[7:0]}} : sz == SZ_HALF ? {(NB/2){ex_b[15:0]}} : ex_b;
    b8 = 8'(rdata >> {ex_alu[1:0], 3'b000});
    h16 = 16'(rdata >> {ex_alu[1], 4'b0000});
    ld = bad ? '0 : sz == SZ_BYTE ? {{(DATA_WIDTH-8){~ex_uns & b8[7]}}, b8}
       : sz == SZ_HALF ? {{(DATA_WIDTH-16){~ex_uns & h16[15]}}, h16} : rdata;
  end
  data_memory #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_mem (
    .clk(i_clk),
    .be(be),
    .addr(ex_alu[AW+1:2]),
    .wdata(wdata),
    .rdata(rdata),
    .dbg_addr(i_debug_addr),
    .dbg_data(o_debug_data)
  );
  assign o_exmem_aluresult = ex_alu;
  assign o_exmem_rd = ex_rd;
  assign o_exmem_regwrite = ex_wb[WB_REGWRITE];
endmodule
